spi_master: RTL and testbench
=============================

# spi_master

Transaction-level SPI master for the lab SPI memory: one 7-bit address, one R/W bit and one 8-bit data byte per chip-select window.
- Generates `cs_pin`, `sclk_pin` and `mosi_pin`; samples `miso_pin`.
- Sits between the on-chip controller (`start`/`busy`/`done` handshake) and the external pins that drive the existing SPI slave FSM.
- Mode 0, MSB first: SCLK idles low, MOSI changes while SCLK is low, and both ends sample on SCLK rising edges.

## Interface
Parameters:
- `CLKDIV`, default 4: `clk` cycles per SCLK half-period; legal range ≥1.
- `ADDR_W`, default 7: address bits.
- `DATA_W`, default 8: data bits.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a transaction; sampled only while `busy`=0.
- `rw` in 1: 1 = read, 0 = write; captured with `start`.
- `addr` in ADDR_W: target address; captured with `start`.
- `wdata` in DATA_W: write byte; captured with `start`, ignored for reads.
- `busy` out 1: high from the cycle after acceptance until the transaction ends.
- `done` out 1: one-cycle pulse at the end of every transaction, read or write.
- `rdata` out DATA_W: last read byte; updates only when a read completes.
- `cs_pin` out 1: active-low chip select.
- `sclk_pin` out 1: serial clock.
- `mosi_pin` out 1: master-out serial data.
- `miso_pin` in 1: slave-out serial data.

## Operation
- Reset values: `cs_pin`=1, `sclk_pin`=0, `mosi_pin`=0, `busy`=0, `done`=0, `rdata`=0, state IDLE.
- Reset asserted mid-transaction: the transaction is aborted and all outputs return to reset values on the next edge. No `done` pulse is produced.
- Frame format, 16 SCLK periods: `addr[6:0]` MSB first, then `rw`, then 8 data bits.
  - Write: master drives `wdata[7:0]` MSB first.
  - Read: master holds `mosi_pin`=0 and samples `miso_pin` at rising edges 9–16, MSB first.
- State machine:
  - IDLE: `start`=1 → SETUP. Capture `{addr, rw}` into the TX shift register and `wdata` into the data register.
  - SETUP: `cs_pin`=0, `mosi_pin`=frame bit 0. Lasts CLKDIV cycles → SHIFT.
  - SHIFT: `sclk_pin` toggles every CLKDIV cycles for 32 half-periods.
    - On each falling edge, `mosi_pin` advances to the next frame bit.
    - At rising edges 9–16 of a read, the value of `miso_pin` in the cycle before the edge is shifted into the RX register.
    - After the 16th falling edge → HOLD.
  - HOLD: `sclk_pin`=0, `cs_pin`=0 for CLKDIV cycles → GAP.
  - GAP: `cs_pin`=1, `mosi_pin`=0, `busy`=1 for CLKDIV cycles → IDLE.
    - `done`=1 in the first GAP cycle only.
    - For reads, `rdata` loads from the RX register in that same cycle.
- Behaviour of `start`:
  - Ignored whenever `busy`=1; no queueing.
  - Asserted on the first IDLE cycle after GAP, it is accepted normally, giving back-to-back transactions with a cs-high gap of ≥CLKDIV+1 cycles.
- A write never changes `rdata`.

## Timing
- Cycle 0 is the edge that accepts `start`. From cycle 1 on: `busy`=1, `cs_pin`=0, `mosi_pin`=`addr[6]`.
- First SCLK rise occurs at cycle 1+CLKDIV. Rise k occurs at cycle 1+CLKDIV·(2k−1); fall k at 1+CLKDIV·2k.
- `cs_pin` is low for exactly 34·CLKDIV cycles.
- `done` pulses at cycle 1+34·CLKDIV. `busy` falls at 1+35·CLKDIV.
- MOSI setup to each rising SCLK edge: CLKDIV cycles. MOSI hold after the edge: CLKDIV cycles.
- All pin outputs come directly from registers; no combinational path from inputs to pins.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP; 3-bit encoding);
  - `ADDR_W`/`DATA_W` defaults;
  - `RW_READ`=1'b1 and `FRAME_BITS`=16.
  - The slave FSM and the bench use the same package.
- One sub-module, `spi_clkdiv`: counter of width $clog2(CLKDIV+1) that produces a one-cycle `half_tick` every CLKDIV cycles. It is enabled and cleared by the master FSM.
- The master holds the FSM, a 5-bit half-period counter, the TX shift register and the RX shift register.

## Test plan
All scenarios use CLKDIV=2, with a behavioural slave model attached for read scenarios.
- Write: `addr`=0x05, `rw`=0, `wdata`=0xA5 → MOSI samples at rises 1–16 are 0000101 0 10100101. `cs_pin` low for 68 cycles; `done` pulses once at cycle 69; `rdata` stays 0.
- Read: `addr`=0x7F, `rw`=1, slave returns 0x3C → MOSI samples 1111111 1 then zeros. `rdata`=0x3C in the `done` cycle, and it holds through a following write.
- `start` pulsed at cycles 5 and 40 during a transaction → ignored. Exactly one `done` pulse; frame unchanged.
- `reset` at cycle 30 mid-read → next cycle `cs_pin`=1, `sclk_pin`=0, `busy`=0, `rdata`=0. No `done` pulse.
- `start` held high continuously → back-to-back frames. `cs_pin` high ≥3 cycles between frames; one `done` per frame.
- CLKDIV=1 write of 0xFF to 0x00 → SCLK period 2 cycles; `cs_pin` low for 34 cycles; bit pattern correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the lab SPI memory master, slave and bench.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam int   ADDR_W_DEF = 7;
  localparam int   DATA_W_DEF = 8;
  localparam logic RW_READ    = 1'b1;
  localparam int   FRAME_BITS = 16;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator: one-cycle half_tick every CLKDIV enabled cycles.
module spi_clkdiv #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic half_tick
);

  localparam int CW = $clog2(CLKDIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    half_tick = en && (cnt_q == CW'(CLKDIV - 1));
    cnt_d     = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = half_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one {addr, rw, data} frame per chip-select window.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs_pin,
  output logic              sclk_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  localparam int FRAME = ADDR_W + 1 + DATA_W;
  localparam int HP_W  = $clog2(2 * FRAME);

  state_e            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [FRAME-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              div_en, div_clr;

  spi_clkdiv #(.CLKDIV(CLKDIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .en        (div_en),
    .clr       (div_clr),
    .half_tick (tick)
  );

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_en  = (state_q != IDLE);
    div_clr = (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tx_d    = {addr, rw,
                     (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
          rw_d    = rw;
          cs_d    = 1'b0;
          mosi_d  = addr[ADDR_W-1];
          busy_d  = 1'b1;
          hp_d    = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (hp_q == HP_W'(2 * FRAME - 1)) begin
            state_d = HOLD;
          end else begin
            hp_d   = hp_q + HP_W'(1);
            sclk_d = ~sclk_q;
            if (sclk_q) begin
              mosi_d = tx_q[FRAME-2];
              tx_d   = {tx_q[FRAME-2:0], 1'b0};
            end else if (rw_q == RW_READ &&
                         hp_q >= HP_W'(2 * ADDR_W + 1)) begin
              // odd hp from 15 on marks rises 9..16 (the data phase)
              rx_d = {rx_q[DATA_W-2:0], miso_pin};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q == RW_READ) rdata_d = rx_q;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign cs_pin   = cs_q;
  assign sclk_pin = sclk_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLKDIV=2 and CLKDIV=1 instances, slave model on u0.
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 0, rw0 = 0, miso0 = 0;
  logic [6:0] addr0 = '0;
  logic [7:0] wdata0 = '0, rdata0;
  logic       busy0, done0, cs0, sclk0, mosi0;

  logic       start1 = 0, rw1 = 0, miso1 = 0;
  logic [6:0] addr1 = '0;
  logic [7:0] wdata1 = '0, rdata1;
  logic       busy1, done1, cs1, sclk1, mosi1;

  spi_master #(.CLKDIV(2)) u0 (
    .clk(clk), .reset(reset), .start(start0), .rw(rw0),
    .addr(addr0), .wdata(wdata0), .busy(busy0), .done(done0),
    .rdata(rdata0), .cs_pin(cs0), .sclk_pin(sclk0),
    .mosi_pin(mosi0), .miso_pin(miso0)
  );

  spi_master #(.CLKDIV(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw1),
    .addr(addr1), .wdata(wdata1), .busy(busy1), .done(done1),
    .rdata(rdata1), .cs_pin(cs1), .sclk_pin(sclk1),
    .mosi_pin(mosi1), .miso_pin(miso1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbyte = '0;
  logic [7:0] model_rd [2] = '{8'h00, 8'h00};
  int sfall = 0;

  // Slave model: presents data bits after falls 8..15, MSB first.
  always @(negedge cs0) begin
    sfall = 0;
    miso0 = 1'b0;
  end
  always @(negedge sclk0) begin
    if (!cs0) begin
      sfall++;
      if (sfall >= 8 && sfall < 16) miso0 = sbyte[15-sfall];
      else miso0 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input int w, input logic [6:0] a,
                       input logic r, input logic [7:0] wd,
                       input logic [7:0] sb, input int p1,
                       input int p2, input bit keep);
    int k;
    int last;
    logic [15:0] exp_f;
    logic [15:0] got_f;
    int nrise, badrise, cslow, csh, ndone, dcyc, badbusy;
    logic pm, ps, cs, sc, mo, bz, dn;
    logic [7:0] rd, rd_done, exp_rd;
    k = (w == 0) ? 2 : 1;
    last = 35 * k + 1;
    exp_f = {a, r, r ? 8'h00 : wd};
    exp_rd = r ? sb : model_rd[w];
    got_f = '0;
    nrise = 0; badrise = 0; cslow = 0; csh = 0;
    ndone = 0; dcyc = -1; badbusy = 0;
    rd_done = 8'hxx;
    pm = 1'b0; ps = 1'b0;
    sbyte = sb;
    @(negedge clk);
    if (w == 0) begin
      start0 = 1; rw0 = r; addr0 = a; wdata0 = wd;
    end else begin
      start1 = 1; rw1 = r; addr1 = a; wdata1 = wd;
    end
    @(posedge clk); #1;
    if (w == 0) begin
      if (!keep) start0 = 0;
      addr0 = 7'($urandom); wdata0 = 8'($urandom); rw0 = ~r;
    end else begin
      start1 = 0;
      addr1 = 7'($urandom); wdata1 = 8'($urandom); rw1 = ~r;
    end
    for (int t = 1; t <= last; t++) begin
      if (w == 0) begin
        cs = cs0; sc = sclk0; mo = mosi0; bz = busy0;
        dn = done0; rd = rdata0;
      end else begin
        cs = cs1; sc = sclk1; mo = mosi1; bz = busy1;
        dn = done1; rd = rdata1;
      end
      if (sc && !ps) begin
        got_f = {got_f[14:0], pm};
        nrise++;
        if (t != 1 + k * (2 * nrise - 1)) badrise++;
      end
      if (!cs) cslow++;
      else csh++;
      if (dn) begin
        ndone++; dcyc = t; rd_done = rd;
      end
      if (bz !== (t <= 35 * k)) badbusy++;
      pm = mo; ps = sc;
      if (w == 0 && !keep) start0 = (t == p1 || t == p2);
      if (t < last) begin
        @(posedge clk); #1;
      end
    end
    if (r) model_rd[w] = sb;
    chk("mosi_frame", got_f, exp_f);
    chk("rise_count", nrise, 16);
    chk("rise_timing", badrise, 0);
    chk("cs_low_cycles", cslow, 34 * k);
    chk("cs_high_gap", csh, k + 1);
    chk("done_count", ndone, 1);
    chk("done_cycle", dcyc, 1 + 34 * k);
    chk("busy_window", badbusy, 0);
    chk("rdata_at_done", rd_done, exp_rd);
    chk("rdata_after", (w == 0) ? rdata0 : rdata1, model_rd[w]);
  endtask

  initial begin
    int nd, csbad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs0, 1'b1);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_cs1", cs1, 1'b1);
    @(negedge clk);
    reset = 0;
    repeat (2) @(posedge clk);

    frame(0, 7'h05, 1'b0, 8'hA5, 8'h00, 0, 0, 0);
    frame(0, 7'h7F, 1'b1, 8'h96, 8'h3C, 0, 0, 0);
    frame(0, 7'h2A, 1'b0, 8'h11, 8'h00, 0, 0, 0);
    frame(0, 7'h33, 1'b0, 8'hC3, 8'h00, 5, 40, 0);

    frame(0, 7'h41, 1'b0, 8'h0F, 8'h00, 0, 0, 1);
    frame(0, 7'h12, 1'b1, 8'h00, 8'h81, 0, 0, 1);
    frame(0, 7'h6E, 1'b0, 8'hF0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 6; i++)
      frame(0, 7'($urandom), 1'($urandom), 8'($urandom),
            8'($urandom), 0, 0, 0);

    frame(0, 7'h19, 1'b1, 8'h00, 8'h5A, 0, 0, 0);

    @(negedge clk);
    start0 = 1; rw0 = 1; addr0 = 7'($urandom);
    sbyte = 8'hE7;
    @(posedge clk); #1;
    start0 = 0;
    repeat (28) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    chk("abort_cs", cs0, 1'b1);
    chk("abort_sclk", sclk0, 1'b0);
    chk("abort_mosi", mosi0, 1'b0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_rdata", rdata0, 8'h00);
    reset = 0;
    model_rd[0] = 8'h00;
    nd = 0; csbad = 0;
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      if (done0) nd++;
      if (!cs0) csbad++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_cs_idle", csbad, 0);

    frame(0, 7'h55, 1'b0, 8'h3E, 8'h00, 0, 0, 0);
    frame(1, 7'h00, 1'b0, 8'hFF, 8'h00, 0, 0, 0);
    frame(1, 7'($urandom), 1'b0, 8'($urandom), 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
